// File: rtl/nn_pkg.sv
// Shared helpers for the dense-layer neuron cells: result-bus layout,
// index-width calculation and the saturation used when a neuron completes.
package nn_pkg;

    // Widest intermediate value the saturate helper accepts. Callers extend
    // their accumulator to this width before saturating.
    localparam int SAT_W = 160;

    // Which source drives the shared result bus on a given edge.
    typedef enum logic [1:0] {
        BUS_PASS     = 2'd0,
        BUS_UPSTREAM = 2'd1,
        BUS_LOCAL    = 2'd2
    } bus_sel_e;

    // The valid flag sits just above the payload on the result bus.
    function automatic int result_valid_bit(input int data_width);
        return data_width;
    endfunction

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Clamp a wide value into a width-bit range. In unsigned mode the
    // value is never negative, so only the upper bound applies.
    function automatic logic [SAT_W-1:0] saturate(
        input logic [SAT_W-1:0] value,
        input int               width,
        input logic             is_signed
    );
        logic signed [SAT_W-1:0] v_s;
        logic signed [SAT_W-1:0] max_s;
        logic signed [SAT_W-1:0] min_s;
        logic        [SAT_W-1:0] max_u;
        v_s   = $signed(value);
        max_s = $signed((SAT_W'(1) << (width - 1)) - SAT_W'(1));
        min_s = ~max_s;
        max_u = (SAT_W'(1) << width) - SAT_W'(1);
        if (is_signed) begin
            if (v_s > max_s) begin
                return $unsigned(max_s);
            end else if (v_s < min_s) begin
                return $unsigned(min_s);
            end else begin
                return value;
            end
        end else begin
            if (value > max_u) begin
                return max_u;
            end else begin
                return value;
            end
        end
    endfunction

endpackage

// File: rtl/mac_saturate.sv
// Multiply-accumulate datapath of one neuron: product of the streamed value
// with the selected weight, running accumulator, and the saturated final
// result presented combinationally for the completing element.
module mac_saturate
    import nn_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    WEIGHT_AMOUNT = 4,
    parameter bit                    SIGNED        = 1'b1,
    parameter logic [DATA_WIDTH-1:0] BIAS          = '0,
    parameter int                    ACC_WIDTH     = 2*DATA_WIDTH + clog2(WEIGHT_AMOUNT) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc_enable,
    input  logic                  acc_restart,
    input  logic [DATA_WIDTH-1:0] mul_value,
    input  logic [DATA_WIDTH-1:0] mul_weight,
    output logic [DATA_WIDTH-1:0] final_value
);

    localparam int   PROD_W    = 2*DATA_WIDTH;
    localparam logic BIAS_FILL = SIGNED ? BIAS[DATA_WIDTH-1] : 1'b0;
    localparam logic [ACC_WIDTH-1:0] BIAS_EXT =
        {{(ACC_WIDTH-DATA_WIDTH){BIAS_FILL}}, BIAS};

    logic [ACC_WIDTH-1:0]        r_acc;
    logic [PROD_W-1:0]           w_product_raw;
    logic [ACC_WIDTH-1:0]        w_product_ext;
    logic [ACC_WIDTH-1:0]        w_sum;
    logic                        w_sum_fill;
    logic [SAT_W-1:0]            w_sum_wide;
    logic [SAT_W-1:0]            w_sat;
    logic [SAT_W-DATA_WIDTH-1:0] w_unused_sat_hi;

    // Operands are widened to the full product width first so the
    // multiply is exact in either signedness.
    generate
        if (SIGNED) begin : g_signed
            logic signed [PROD_W-1:0] w_a_ext;
            logic signed [PROD_W-1:0] w_b_ext;
            assign w_a_ext       = $signed({{DATA_WIDTH{mul_value[DATA_WIDTH-1]}}, mul_value});
            assign w_b_ext       = $signed({{DATA_WIDTH{mul_weight[DATA_WIDTH-1]}}, mul_weight});
            assign w_product_raw = $unsigned(w_a_ext * w_b_ext);
            assign w_product_ext = {{(ACC_WIDTH-PROD_W){w_product_raw[PROD_W-1]}}, w_product_raw};
            assign w_sum_fill    = w_sum[ACC_WIDTH-1];
        end else begin : g_unsigned
            logic [PROD_W-1:0] w_a_ext;
            logic [PROD_W-1:0] w_b_ext;
            assign w_a_ext       = {{DATA_WIDTH{1'b0}}, mul_value};
            assign w_b_ext       = {{DATA_WIDTH{1'b0}}, mul_weight};
            assign w_product_raw = w_a_ext * w_b_ext;
            assign w_product_ext = {{(ACC_WIDTH-PROD_W){1'b0}}, w_product_raw};
            assign w_sum_fill    = 1'b0;
        end
    endgenerate

    assign w_sum           = r_acc + w_product_ext;
    assign w_sum_wide      = {{(SAT_W-ACC_WIDTH){w_sum_fill}}, w_sum};
    assign w_sat           = saturate(w_sum_wide, DATA_WIDTH, SIGNED);
    assign final_value     = w_sat[DATA_WIDTH-1:0];
    assign w_unused_sat_hi = w_sat[SAT_W-1:DATA_WIDTH];

    // Running sum; restarts from the bias on completion so the next neuron
    // never sees a stale partial sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= BIAS_EXT;
        end else if (acc_enable) begin
            r_acc <= acc_restart ? BIAS_EXT : w_sum;
        end
    end

endmodule

// File: rtl/loadable_weight_cell.sv
// Systolic neuron cell with run-time loadable weights. Streams the layer
// input through with one cycle of delay, accumulates its own neuron, and
// merges its result onto the shared result bus behind upstream traffic via
// a one-entry pending buffer. Protocol faults raise sticky flags.
module loadable_weight_cell
    import nn_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    WEIGHT_AMOUNT = 4,
    parameter bit                    SIGNED        = 1'b1,
    parameter logic [DATA_WIDTH-1:0] BIAS          = '0,
    parameter int                    ACC_WIDTH     = 2*DATA_WIDTH + clog2(WEIGHT_AMOUNT) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  weight_load_enable,
    input  logic [DATA_WIDTH-1:0] weight_load_index,
    input  logic [DATA_WIDTH-1:0] weight_load_value,
    input  logic [DATA_WIDTH-1:0] input_index,
    input  logic [DATA_WIDTH-1:0] input_value,
    input  logic                  input_enable,
    input  logic [DATA_WIDTH:0]   input_result,
    output logic [DATA_WIDTH-1:0] output_index,
    output logic [DATA_WIDTH-1:0] output_value,
    output logic                  output_enable,
    output logic [DATA_WIDTH:0]   output_result,
    output logic                  index_error,
    output logic                  result_overflow
);

    localparam int VB    = result_valid_bit(DATA_WIDTH);
    localparam int IDX_W = clog2(WEIGHT_AMOUNT);
    localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(WEIGHT_AMOUNT - 1);
    localparam logic [DATA_WIDTH-1:0] AMOUNT   = DATA_WIDTH'(WEIGHT_AMOUNT);

    // Registered state
    logic [DATA_WIDTH-1:0] r_output_index;
    logic [DATA_WIDTH-1:0] r_output_value;
    logic                  r_output_enable;
    logic [DATA_WIDTH:0]   r_output_result;
    logic [DATA_WIDTH-1:0] r_pending;
    logic                  r_pending_valid;
    logic                  r_index_error;
    logic                  r_result_overflow;

    // Combinational decode
    logic                  w_in_range;
    logic                  w_load_range;
    logic                  w_load_ok;
    logic [IDX_W-1:0]      w_in_sel;
    logic [IDX_W-1:0]      w_load_sel;
    logic                  w_accumulate;
    logic                  w_complete;
    logic                  w_drain;
    logic                  w_store;
    logic [DATA_WIDTH-1:0] w_weight [WEIGHT_AMOUNT];
    logic [DATA_WIDTH-1:0] w_weight_sel;
    logic [DATA_WIDTH-1:0] w_final;
    bus_sel_e              w_bus_sel;

    assign w_in_range   = input_index < AMOUNT;
    assign w_load_range = weight_load_index < AMOUNT;
    assign w_load_ok    = weight_load_enable && w_load_range;
    assign w_in_sel     = input_index[IDX_W-1:0];
    assign w_load_sel   = weight_load_index[IDX_W-1:0];
    assign w_accumulate = input_enable && w_in_range;
    assign w_complete   = w_accumulate && (input_index == LAST_IDX);

    // Weight slots. Reads see the value from before this edge, so a load and
    // an accumulate hitting the same index use the old weight.
    genvar gi;
    generate
        for (gi = 0; gi < WEIGHT_AMOUNT; gi++) begin : g_weight
            logic [DATA_WIDTH-1:0] r_weight;

            // Capture the load value when this slot is addressed.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_weight <= '0;
                end else if (w_load_ok && (w_load_sel == IDX_W'(gi))) begin
                    r_weight <= weight_load_value;
                end
            end

            assign w_weight[gi] = r_weight;
        end
    endgenerate

    assign w_weight_sel = w_in_range ? w_weight[w_in_sel] : '0;

    mac_saturate #(
        .DATA_WIDTH    (DATA_WIDTH),
        .WEIGHT_AMOUNT (WEIGHT_AMOUNT),
        .SIGNED        (SIGNED),
        .BIAS          (BIAS),
        .ACC_WIDTH     (ACC_WIDTH)
    ) u_mac (
        .clk         (clk),
        .rst         (rst),
        .acc_enable  (w_accumulate),
        .acc_restart (w_complete),
        .mul_value   (input_value),
        .mul_weight  (w_weight_sel),
        .final_value (w_final)
    );

    // Bus arbitration: upstream results always win, then our buffered result.
    always_comb begin
        w_bus_sel = BUS_PASS;
        if (input_result[VB]) begin
            w_bus_sel = BUS_UPSTREAM;
        end else if (r_pending_valid) begin
            w_bus_sel = BUS_LOCAL;
        end
    end

    assign w_drain = (w_bus_sel == BUS_LOCAL);
    // A completion fits if the buffer is empty or being emptied this edge.
    assign w_store = w_complete && (!r_pending_valid || w_drain);

    // Pass the input stream to the next cell with one cycle of delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_output_index  <= '0;
            r_output_value  <= '0;
            r_output_enable <= 1'b0;
        end else begin
            r_output_index  <= input_index;
            r_output_value  <= input_value;
            r_output_enable <= input_enable;
        end
    end

    // Drive the result bus from the arbitration winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_output_result <= '0;
        end else begin
            case (w_bus_sel)
                BUS_UPSTREAM: r_output_result <= input_result;
                BUS_LOCAL:    r_output_result <= {1'b1, r_pending};
                default:      r_output_result <= {1'b0, input_result[DATA_WIDTH-1:0]};
            endcase
        end
    end

    // One-entry buffer holding a finished result until the bus is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
        end else if (w_store) begin
            r_pending       <= w_final;
            r_pending_valid <= 1'b1;
        end else if (w_drain) begin
            r_pending_valid <= 1'b0;
        end
    end

    // Sticky fault flags; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index_error     <= 1'b0;
            r_result_overflow <= 1'b0;
        end else begin
            if ((input_enable && !w_in_range) || (weight_load_enable && !w_load_range)) begin
                r_index_error <= 1'b1;
            end
            if (w_complete && !w_store) begin
                r_result_overflow <= 1'b1;
            end
        end
    end

    assign output_index    = r_output_index;
    assign output_value    = r_output_value;
    assign output_enable   = r_output_enable;
    assign output_result   = r_output_result;
    assign index_error     = r_index_error;
    assign result_overflow = r_result_overflow;

endmodule

// File: tb/tb_loadable_weight_cell.sv
// Directed bench for loadable_weight_cell: a 32-bit signed cell with zero
// bias plus two 8-bit cells (signed and unsigned, bias 5) driven by a shared
// 8-bit stimulus.
module tb_loadable_weight_cell;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit signed cell, BIAS = 0
    logic        a_wl_en = 1'b0;
    logic [31:0] a_wl_idx = '0, a_wl_val = '0, a_in_idx = '0, a_in_val = '0;
    logic        a_in_en = 1'b0;
    logic [32:0] a_in_res = '0;
    logic [31:0] a_o_idx, a_o_val;
    logic        a_o_en, a_ierr, a_ovf;
    logic [32:0] a_o_res;

    // 8-bit cells, BIAS = 5
    logic        b_wl_en = 1'b0;
    logic [7:0]  b_wl_idx = '0, b_wl_val = '0, b_in_idx = '0, b_in_val = '0;
    logic        b_in_en = 1'b0;
    logic [8:0]  b_in_res = '0;
    logic [7:0]  s_o_idx, s_o_val, u_o_idx, u_o_val;
    logic        s_o_en, s_ierr, s_ovf, u_o_en, u_ierr, u_ovf;
    logic [8:0]  s_o_res, u_o_res;

    int check_cnt = 0;
    int pass_cnt  = 0;

    loadable_weight_cell #(.DATA_WIDTH(32), .WEIGHT_AMOUNT(4), .SIGNED(1), .BIAS(32'd0)) dut (
        .clk(clk), .rst(rst),
        .weight_load_enable(a_wl_en), .weight_load_index(a_wl_idx), .weight_load_value(a_wl_val),
        .input_index(a_in_idx), .input_value(a_in_val), .input_enable(a_in_en), .input_result(a_in_res),
        .output_index(a_o_idx), .output_value(a_o_val), .output_enable(a_o_en), .output_result(a_o_res),
        .index_error(a_ierr), .result_overflow(a_ovf)
    );

    loadable_weight_cell #(.DATA_WIDTH(8), .WEIGHT_AMOUNT(4), .SIGNED(1), .BIAS(8'd5)) dut_s8 (
        .clk(clk), .rst(rst),
        .weight_load_enable(b_wl_en), .weight_load_index(b_wl_idx), .weight_load_value(b_wl_val),
        .input_index(b_in_idx), .input_value(b_in_val), .input_enable(b_in_en), .input_result(b_in_res),
        .output_index(s_o_idx), .output_value(s_o_val), .output_enable(s_o_en), .output_result(s_o_res),
        .index_error(s_ierr), .result_overflow(s_ovf)
    );

    loadable_weight_cell #(.DATA_WIDTH(8), .WEIGHT_AMOUNT(4), .SIGNED(0), .BIAS(8'd5)) dut_u8 (
        .clk(clk), .rst(rst),
        .weight_load_enable(b_wl_en), .weight_load_index(b_wl_idx), .weight_load_value(b_wl_val),
        .input_index(b_in_idx), .input_value(b_in_val), .input_enable(b_in_en), .input_result(b_in_res),
        .output_index(u_o_idx), .output_value(u_o_val), .output_enable(u_o_en), .output_result(u_o_res),
        .index_error(u_ierr), .result_overflow(u_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_wl_en = 1'b0; a_in_en = 1'b0; a_in_res = '0;
        b_wl_en = 1'b0; b_in_en = 1'b0; b_in_res = '0;
    endtask

    task automatic load_a(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            a_wl_en = 1'b1; a_wl_idx = 32'(i); a_wl_val = w[i];
            step();
        end
        a_wl_en = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input logic [7:0] w3);
        logic [7:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            b_wl_en = 1'b1; b_wl_idx = 8'(i); b_wl_val = w[i];
            step();
        end
        b_wl_en = 1'b0;
    endtask

    // Stream one neuron of constant value into the 32-bit cell, idx 0..3.
    task automatic stream_a(input logic [31:0] val);
        for (int i = 0; i < 4; i++) begin
            a_in_en = 1'b1; a_in_idx = 32'(i); a_in_val = val;
            step();
        end
        a_in_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        check_cnt++; if (a_o_res !== 33'd0) $display("FAIL reset_a_result got=%h want=%h", a_o_res, 33'd0); else pass_cnt++;
        check_cnt++; if ({a_o_en, a_o_idx, a_o_val} !== 65'd0) $display("FAIL reset_a_stream got=%h want=0", {a_o_en, a_o_idx, a_o_val}); else pass_cnt++;
        check_cnt++; if ({a_ierr, a_ovf, s_ierr, s_ovf, u_ierr, u_ovf} !== 6'd0) $display("FAIL reset_flags got=%b want=000000", {a_ierr, a_ovf, s_ierr, s_ovf, u_ierr, u_ovf}); else pass_cnt++;
        check_cnt++; if ({s_o_res, u_o_res} !== 18'd0) $display("FAIL reset_b_result got=%h want=0", {s_o_res, u_o_res}); else pass_cnt++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        load_a(32'd4, 32'd3, 32'd2, 32'd1);
        load_b(8'd4, 8'd3, 8'd2, 8'd1);
        for (int i = 0; i < 4; i++) begin
            a_in_en = 1'b1; a_in_idx = 32'(i); a_in_val = 32'd1;
            b_in_en = 1'b1; b_in_idx = 8'(i);  b_in_val = 8'd1;
            step();
            check_cnt++;
            if ({a_o_en, a_o_idx, a_o_val} !== {1'b1, 32'(i), 32'd1})
                $display("FAIL basic_mirror[%0d] got=%h want=%h", i, {a_o_en, a_o_idx, a_o_val}, {1'b1, 32'(i), 32'd1});
            else pass_cnt++;
        end
        clear_inputs();
        check_cnt++; if (a_o_res !== 33'd0) $display("FAIL basic_not_yet got=%h want=%h", a_o_res, 33'd0); else pass_cnt++;
        step();
        check_cnt++; if (a_o_res !== {1'b1, 32'd10}) $display("FAIL basic_result got=%h want=%h", a_o_res, {1'b1, 32'd10}); else pass_cnt++;
        check_cnt++; if (s_o_res !== {1'b1, 8'd15}) $display("FAIL basic_bias_s got=%h want=%h", s_o_res, {1'b1, 8'd15}); else pass_cnt++;
        check_cnt++; if (u_o_res !== {1'b1, 8'd15}) $display("FAIL basic_bias_u got=%h want=%h", u_o_res, {1'b1, 8'd15}); else pass_cnt++;
        check_cnt++; if (a_o_en !== 1'b0) $display("FAIL basic_en_drop got=%b want=0", a_o_en); else pass_cnt++;
        step();
        check_cnt++; if (a_o_res !== 33'd0) $display("FAIL basic_single_pulse got=%h want=%h", a_o_res, 33'd0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp_a;
        logic [8:0]  exp_b;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                a_in_en = 1'b1; a_in_idx = 32'(c % 4); a_in_val = (c < 4) ? 32'd1 : 32'd2;
                b_in_en = 1'b1; b_in_idx = 8'(c % 4);  b_in_val = (c < 4) ? 8'd1 : 8'd2;
            end else begin
                clear_inputs();
            end
            step();
            exp_a = (c == 4) ? {1'b1, 32'd10} : (c == 8) ? {1'b1, 32'd20} : 33'd0;
            exp_b = (c == 4) ? {1'b1, 8'd15}  : (c == 8) ? {1'b1, 8'd25}  : 9'd0;
            check_cnt++; if (a_o_res !== exp_a) $display("FAIL b2b_a[%0d] got=%h want=%h", c, a_o_res, exp_a); else pass_cnt++;
            check_cnt++; if ({s_o_res, u_o_res} !== {exp_b, exp_b}) $display("FAIL b2b_b[%0d] got=%h want=%h", c, {s_o_res, u_o_res}, {exp_b, exp_b}); else pass_cnt++;
        end
    endtask

    task automatic test_signed_sat();
        load_a(32'd1, 32'd1, 32'd1, 32'd1);
        load_b(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        for (int c = 0; c < 9; c++) begin
            a_in_en = (c < 4); a_in_idx = 32'(c % 4); a_in_val = 32'hFFFF_FFFD;
            b_in_en = (c < 8); b_in_idx = 8'(c % 4);  b_in_val = (c < 4) ? 8'h7F : 8'h80;
            step();
            if (c == 4) begin
                check_cnt++; if (a_o_res !== {1'b1, 32'hFFFF_FFF4}) $display("FAIL signed_neg got=%h want=%h", a_o_res, {1'b1, 32'hFFFF_FFF4}); else pass_cnt++;
                check_cnt++; if (s_o_res !== {1'b1, 8'h7F}) $display("FAIL sat_pos_s got=%h want=%h", s_o_res, {1'b1, 8'h7F}); else pass_cnt++;
                check_cnt++; if (u_o_res !== {1'b1, 8'hFF}) $display("FAIL sat_pos_u got=%h want=%h", u_o_res, {1'b1, 8'hFF}); else pass_cnt++;
            end
            if (c == 8) begin
                check_cnt++; if (s_o_res !== {1'b1, 8'h80}) $display("FAIL sat_neg_s got=%h want=%h", s_o_res, {1'b1, 8'h80}); else pass_cnt++;
                check_cnt++; if (u_o_res !== {1'b1, 8'hFF}) $display("FAIL sat_big_u got=%h want=%h", u_o_res, {1'b1, 8'hFF}); else pass_cnt++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_arbitration();
        load_a(32'd4, 32'd3, 32'd2, 32'd1);
        stream_a(32'd1);
        a_in_res = {1'b1, 32'd7};
        step();
        check_cnt++; if (a_o_res !== {1'b1, 32'd7}) $display("FAIL arb_up7 got=%h want=%h", a_o_res, {1'b1, 32'd7}); else pass_cnt++;
        a_in_res = {1'b1, 32'd8};
        step();
        check_cnt++; if (a_o_res !== {1'b1, 32'd8}) $display("FAIL arb_up8 got=%h want=%h", a_o_res, {1'b1, 32'd8}); else pass_cnt++;
        a_in_res = {1'b0, 32'h1234};
        step();
        check_cnt++; if (a_o_res !== {1'b1, 32'd10}) $display("FAIL arb_local got=%h want=%h", a_o_res, {1'b1, 32'd10}); else pass_cnt++;
        step();
        check_cnt++; if (a_o_res !== {1'b0, 32'h1234}) $display("FAIL arb_pass got=%h want=%h", a_o_res, {1'b0, 32'h1234}); else pass_cnt++;
        a_in_res = '0;
    endtask

    task automatic test_drain_collide();
        logic [32:0] exp_a;
        stream_a(32'd1);
        for (int j = 0; j < 4; j++) begin
            a_in_en = 1'b1; a_in_idx = 32'(j); a_in_val = 32'd2;
            a_in_res = (j < 3) ? {1'b1, 32'(100 + j)} : 33'd0;
            step();
            exp_a = (j < 3) ? {1'b1, 32'(100 + j)} : {1'b1, 32'd10};
            check_cnt++; if (a_o_res !== exp_a) $display("FAIL collide_bus[%0d] got=%h want=%h", j, a_o_res, exp_a); else pass_cnt++;
        end
        clear_inputs();
        check_cnt++; if (a_ovf !== 1'b0) $display("FAIL collide_no_ovf got=%b want=0", a_ovf); else pass_cnt++;
        step();
        check_cnt++; if (a_o_res !== {1'b1, 32'd20}) $display("FAIL collide_new got=%h want=%h", a_o_res, {1'b1, 32'd20}); else pass_cnt++;
    endtask

    task automatic test_overflow();
        stream_a(32'd1);
        for (int j = 0; j < 4; j++) begin
            a_in_en = 1'b1; a_in_idx = 32'(j); a_in_val = 32'd2;
            a_in_res = {1'b1, 32'(200 + j)};
            step();
            check_cnt++; if (a_o_res !== {1'b1, 32'(200 + j)}) $display("FAIL ovf_bus[%0d] got=%h want=%h", j, a_o_res, {1'b1, 32'(200 + j)}); else pass_cnt++;
            check_cnt++; if (a_ovf !== (j == 3)) $display("FAIL ovf_flag[%0d] got=%b want=%b", j, a_ovf, (j == 3)); else pass_cnt++;
        end
        clear_inputs();
        step();
        check_cnt++; if (a_o_res !== {1'b1, 32'd10}) $display("FAIL ovf_kept got=%h want=%h", a_o_res, {1'b1, 32'd10}); else pass_cnt++;
        step();
        check_cnt++; if (a_o_res !== 33'd0) $display("FAIL ovf_dropped got=%h want=%h", a_o_res, 33'd0); else pass_cnt++;
        check_cnt++; if (a_ovf !== 1'b1) $display("FAIL ovf_sticky got=%b want=1", a_ovf); else pass_cnt++;
    endtask

    task automatic test_index_error();
        check_cnt++; if (a_ierr !== 1'b0) $display("FAIL idx_clean got=%b want=0", a_ierr); else pass_cnt++;
        a_in_en = 1'b1; a_in_idx = 32'd0; a_in_val = 32'd1;
        step();
        a_in_idx = 32'd5; a_in_val = 32'd100;
        step();
        check_cnt++; if (a_o_idx !== 32'd5) $display("FAIL idx_passthru got=%h want=%h", a_o_idx, 32'd5); else pass_cnt++;
        check_cnt++; if (a_ierr !== 1'b1) $display("FAIL idx_stream_err got=%b want=1", a_ierr); else pass_cnt++;
        for (int i = 1; i < 4; i++) begin
            a_in_idx = 32'(i); a_in_val = 32'd1;
            step();
        end
        clear_inputs();
        step();
        check_cnt++; if (a_o_res !== {1'b1, 32'd10}) $display("FAIL idx_sum_intact got=%h want=%h", a_o_res, {1'b1, 32'd10}); else pass_cnt++;

        // Out-of-range loads: index 4 would alias slot 0 if not rejected.
        check_cnt++; if (s_ierr !== 1'b0) $display("FAIL load_err_before got=%b want=0", s_ierr); else pass_cnt++;
        a_wl_en = 1'b1; a_wl_idx = 32'd4; a_wl_val = 32'd50;
        b_wl_en = 1'b1; b_wl_idx = 8'd4;  b_wl_val = 8'd50;
        step();
        clear_inputs();
        check_cnt++; if ({s_ierr, u_ierr} !== 2'b11) $display("FAIL load_err_set got=%b want=11", {s_ierr, u_ierr}); else pass_cnt++;
        check_cnt++; if (a_ierr !== 1'b1) $display("FAIL load_err_sticky got=%b want=1", a_ierr); else pass_cnt++;

        // Load idx 2 = 9 on the same edge as streaming idx 2.
        for (int i = 0; i < 4; i++) begin
            a_in_en = 1'b1; a_in_idx = 32'(i); a_in_val = 32'd1;
            a_wl_en = (i == 2); a_wl_idx = 32'd2; a_wl_val = 32'd9;
            step();
        end
        clear_inputs();
        step();
        check_cnt++; if (a_o_res !== {1'b1, 32'd10}) $display("FAIL load_old_weight got=%h want=%h", a_o_res, {1'b1, 32'd10}); else pass_cnt++;
        stream_a(32'd1);
        step();
        check_cnt++; if (a_o_res !== {1'b1, 32'd17}) $display("FAIL load_new_weight got=%h want=%h", a_o_res, {1'b1, 32'd17}); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            a_in_en = 1'b1; a_in_idx = 32'(i); a_in_val = 32'd1;
            step();
        end
        rst = 1'b1;
        #1;
        check_cnt++; if ({a_o_en, a_o_idx, a_o_val, a_o_res} !== 98'd0) $display("FAIL rstmid_a_out got=%h want=0", {a_o_en, a_o_idx, a_o_val, a_o_res}); else pass_cnt++;
        check_cnt++; if ({a_ierr, a_ovf, s_ierr, u_ierr} !== 4'd0) $display("FAIL rstmid_flags got=%b want=0000", {a_ierr, a_ovf, s_ierr, u_ierr}); else pass_cnt++;
        clear_inputs();
        step();
        rst = 1'b0;
        step();
        load_a(32'd4, 32'd3, 32'd2, 32'd1);
        stream_a(32'd1);
        step();
        check_cnt++; if (a_o_res !== {1'b1, 32'd10}) $display("FAIL rstmid_fresh got=%h want=%h", a_o_res, {1'b1, 32'd10}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_signed_sat();
        test_arbitration();
        test_drain_collide();
        test_overflow();
        test_index_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
